bioee_dac_array_ctrl: RTL and testbench

Parametrised serial controller for an array of N_CH 3-wire DACs that share one serial clock. Each DAC has its own data line and its own load strobe. Host words arrive through a ready/valid frame port from the pipe-in decode. Each frame is double-buffered, shifted MSB-first to every enabled channel in parallel, and committed either automatically or on a host set trigger. This allows simultaneous update of working-electrode, RE and ADC-reference DACs.

---
 rtl/bioee_dac_pkg.sv | 19 +
 rtl/bioee_tick_gen.sv | 32 +++
 rtl/bioee_dac_array_ctrl.sv | 138 +++++++++++++
 tb/tb_bioee_dac_array_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bioee_dac_pkg.sv
// Shared types and width helpers for the DAC array serial controller.
package bioee_dac_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_SET = 2'd2,
    LOAD     = 2'd3
  } engState_t;

  function automatic int bitCntWidth(input int dataW);
    return $clog2(dataW + 1);
  endfunction

  function automatic int phaseWidth(input int clkDiv);
    return $clog2(clkDiv);
  endfunction

endpackage

// File: rtl/bioee_tick_gen.sv
// Divider phase counter producing clk-domain enables at the sclk rising point and at wrap.
module bioee_tick_gen
  import bioee_dac_pkg::*;
#(
  parameter int CLK_DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick_rise,
  output logic tick_wrap
);

  localparam int PW = phaseWidth(CLK_DIV);
  localparam logic [PW-1:0] RISE_CNT = PW'(CLK_DIV / 2 - 1);
  localparam logic [PW-1:0] WRAP_CNT = PW'(CLK_DIV - 1);

  logic [PW-1:0] phaseQ;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      phaseQ <= '0;
    end else if (run) begin
      phaseQ <= tick_wrap ? '0 : phaseQ + PW'(1);
    end
  end

  assign tick_rise = run && (phaseQ == RISE_CNT);
  assign tick_wrap = run && (phaseQ == WRAP_CNT);

endmodule

// File: rtl/bioee_dac_array_ctrl.sv
// Double-buffered serial controller for N_CH 3-wire DACs sharing one sclk.
//
// state    | meaning
// IDLE     | no frame in the engine, waiting for the holding register
// SHIFT    | serialising DATA_W bits MSB-first to every enabled channel
// WAIT_SET | armed frame fully shifted, waiting for set_trig
// LOAD     | load strobe for CLK_DIV cycles, then one ack_set cycle
module bioee_dac_array_ctrl
  import bioee_dac_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 10000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH*DATA_W-1:0]   din,
  input  logic [N_CH-1:0]          ch_en,
  input  logic                     mode,
  input  logic                     din_valid,
  output logic                     din_ready,
  input  logic                     set_trig,
  output logic                     ack_data,
  output logic                     ack_set,
  output logic                     busy,
  output logic                     dac_sclk,
  output logic [N_CH-1:0]          dac_din,
  output logic [N_CH-1:0]          dac_load
);

  localparam int BCW = bitCntWidth(DATA_W);
  localparam int FW  = N_CH * DATA_W;

  engState_t        stateQ, stateD;
  logic             holdValid, holdMode;
  logic [FW-1:0]    holdData, shiftQ;
  logic [N_CH-1:0]  holdEn, chEnQ;
  logic             modeQ, trigPendQ, loadDoneQ, sclkQ, ackDataQ;
  logic [BCW-1:0]   bitCntQ;
  logic             tickRise, tickWrap, lastBit, accept, pull;

  assign lastBit = (bitCntQ == BCW'(1));
  assign accept  = din_valid && !holdValid;
  assign pull    = holdValid && ((stateQ == IDLE) || (stateQ == LOAD && loadDoneQ));

  bioee_tick_gen #(.CLK_DIV(CLK_DIV)) uTick (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (stateD != stateQ),
    .run       ((stateQ == SHIFT) || (stateQ == LOAD)),
    .tick_rise (tickRise),
    .tick_wrap (tickWrap)
  );

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:     if (holdValid) stateD = SHIFT;
      // A trigger already seen during the shift skips WAIT_SET entirely.
      SHIFT:    if (tickWrap && lastBit)
                  stateD = (!modeQ || trigPendQ || set_trig) ? LOAD : WAIT_SET;
      WAIT_SET: if (set_trig) stateD = LOAD;
      LOAD:     if (loadDoneQ) stateD = holdValid ? SHIFT : IDLE;
      default:  stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      holdValid <= 1'b0;
      holdMode  <= 1'b0;
      holdData  <= '0;
      holdEn    <= '0;
      shiftQ    <= '0;
      chEnQ     <= '0;
      modeQ     <= 1'b0;
      bitCntQ   <= '0;
      trigPendQ <= 1'b0;
      loadDoneQ <= 1'b0;
      sclkQ     <= 1'b0;
      ackDataQ  <= 1'b0;
    end else begin
      stateQ    <= stateD;
      ackDataQ  <= accept;
      holdValid <= accept || (holdValid && !pull);
      loadDoneQ <= (stateQ == LOAD) && tickWrap && !loadDoneQ;

      if (accept) begin
        holdData <= din;
        holdEn   <= ch_en;
        holdMode <= mode;
      end

      if (pull) begin
        shiftQ  <= holdData;
        chEnQ   <= holdEn;
        modeQ   <= holdMode;
        bitCntQ <= BCW'(DATA_W);
      end else if (stateQ == SHIFT && tickWrap) begin
        bitCntQ <= bitCntQ - BCW'(1);
        // The final bit is held on the data lines through WAIT_SET and LOAD.
        if (!lastBit) begin
          for (int k = 0; k < N_CH; k++)
            shiftQ[k*DATA_W +: DATA_W] <= {shiftQ[k*DATA_W +: DATA_W-1], 1'b0};
        end
      end

      if (pull || stateQ == LOAD)
        trigPendQ <= 1'b0;
      else if (stateQ == SHIFT && modeQ && set_trig)
        trigPendQ <= 1'b1;

      if (stateQ == SHIFT) begin
        if (tickRise)      sclkQ <= 1'b1;
        else if (tickWrap) sclkQ <= 1'b0;
      end else begin
        sclkQ <= 1'b0;
      end
    end
  end

  always_comb begin
    dac_din = '0;
    if (stateQ != IDLE) begin
      for (int k = 0; k < N_CH; k++)
        dac_din[k] = chEnQ[k] & shiftQ[k*DATA_W + DATA_W-1];
    end
  end

  assign dac_load  = (stateQ == LOAD && !loadDoneQ) ? chEnQ : '0;
  assign ack_set   = (stateQ == LOAD) && loadDoneQ;
  assign ack_data  = ackDataQ;
  assign din_ready = !holdValid;
  assign busy      = (stateQ != IDLE);
  assign dac_sclk  = sclkQ;

endmodule

// File: tb/tb_bioee_dac_array_ctrl.sv
// Directed bench for bioee_dac_array_ctrl with N_CH=2, DATA_W=8, CLK_DIV=4.
module tb_bioee_dac_array_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic [1:0]  ch_en;
  logic        mode, din_valid, set_trig;
  logic        din_ready, ack_data, ack_set, busy, dac_sclk;
  logic [1:0]  dac_din, dac_load;

  int nTests = 0;
  int nFail  = 0;
  int nAckData, nAckSet;

  bioee_dac_array_ctrl #(.N_CH(2), .DATA_W(8), .CLK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .ch_en     (ch_en),
    .mode      (mode),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .set_trig  (set_trig),
    .ack_data  (ack_data),
    .ack_set   (ack_set),
    .busy      (busy),
    .dac_sclk  (dac_sclk),
    .dac_din   (dac_din),
    .dac_load  (dac_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts on the first SHIFT cycle, ends on the cycle after the last SHIFT cycle.
  task automatic shiftFrame(input logic [15:0] data, input logic [1:0] en, input int trigAt);
    for (int i = 0; i < 32; i++) begin
      int b;
      logic [1:0] expDin;
      b = i / 4;
      expDin = {en[1] & data[15-b], en[0] & data[7-b]};
      chk("shift_din", 32'(dac_din), 32'(expDin));
      chk("shift_sclk", 32'(dac_sclk), ((i % 4) >= 2) ? 32'd1 : 32'd0);
      chk("shift_load", 32'(dac_load), 32'd0);
      chk("shift_busy", 32'(busy), 32'd1);
      if (i == trigAt) set_trig = 1'b1;
      tick();
      set_trig = 1'b0;
    end
  endtask

  // Starts on the first LOAD cycle, ends on the cycle after ack_set.
  task automatic loadPhase(input logic [1:0] en);
    for (int i = 0; i < 4; i++) begin
      chk("load_strobe", 32'(dac_load), 32'(en));
      chk("load_ack_early", 32'(ack_set), 32'd0);
      tick();
    end
    chk("load_ack", 32'(ack_set), 32'd1);
    chk("load_clear", 32'(dac_load), 32'd0);
    tick();
    chk("load_ack_once", 32'(ack_set), 32'd0);
  endtask

  task automatic offer(input logic [15:0] data, input logic [1:0] en, input logic m);
    din = data; ch_en = en; mode = m; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("accept_ack", 32'(ack_data), 32'd1);
    chk("accept_ready", 32'(din_ready), 32'd0);
    tick();
    chk("ack_data_once", 32'(ack_data), 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; din = '0; ch_en = '0; mode = 1'b0; din_valid = 1'b0; set_trig = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(din_ready), 32'd1);
    chk("rst_outs", {26'd0, busy, dac_sclk, dac_din, dac_load}, 32'd0);
    chk("rst_acks", {30'd0, ack_data, ack_set}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Auto load
    offer(16'hA53C, 2'b11, 1'b0);
    shiftFrame(16'hA53C, 2'b11, -1);
    loadPhase(2'b11);
    chk("auto_idle", 32'(busy), 32'd0);

    // Armed load
    offer(16'h5AC3, 2'b11, 1'b1);
    shiftFrame(16'h5AC3, 2'b11, -1);
    for (int i = 0; i < 10; i++) begin
      chk("wait_sclk", 32'(dac_sclk), 32'd0);
      chk("wait_din", 32'(dac_din), 32'(2'b01));
      chk("wait_load", 32'(dac_load), 32'd0);
      chk("wait_busy", 32'(busy), 32'd1);
      tick();
    end
    set_trig = 1'b1;
    chk("trig_cycle_load", 32'(dac_load), 32'd0);
    tick();
    set_trig = 1'b0;
    loadPhase(2'b11);
    chk("armed_idle", 32'(busy), 32'd0);

    // Early trigger, then a stray trigger in IDLE
    offer(16'h0FF0, 2'b11, 1'b1);
    shiftFrame(16'h0FF0, 2'b11, 13);
    loadPhase(2'b11);
    set_trig = 1'b1;
    tick();
    set_trig = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("stray_load", 32'(dac_load), 32'd0);
      chk("stray_ack", 32'(ack_set), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
      tick();
    end

    // Back-to-back frames
    nAckData = 0;
    nAckSet  = 0;
    fork
      begin : host
        logic [15:0] frames [3];
        frames[0] = 16'h1234; frames[1] = 16'hFEDC; frames[2] = 16'h8001;
        for (int f = 0; f < 3; f++) begin
          int budget;
          din = frames[f]; ch_en = 2'b11; mode = 1'b0; din_valid = 1'b1;
          budget = 0;
          while (!din_ready && budget < 200) begin
            tick();
            budget++;
          end
          chk("b2b_ready_timeout", 32'(din_ready), 32'd1);
          tick();
          chk("b2b_ack_data", 32'(ack_data), 32'd1);
          chk("b2b_ready_drop", 32'(din_ready), 32'd0);
        end
        din_valid = 1'b0;
      end
      begin : engine
        tick();
        tick();
        shiftFrame(16'h1234, 2'b11, -1);
        loadPhase(2'b11);
        shiftFrame(16'hFEDC, 2'b11, -1);
        loadPhase(2'b11);
        shiftFrame(16'h8001, 2'b11, -1);
        loadPhase(2'b11);
        chk("b2b_idle", 32'(busy), 32'd0);
      end
      begin : monitor
        for (int i = 0; i < 130; i++) begin
          if (ack_data) nAckData++;
          if (ack_set)  nAckSet++;
          tick();
        end
      end
    join
    chk("b2b_ack_data_count", 32'(nAckData), 32'd3);
    chk("b2b_ack_set_count", 32'(nAckSet), 32'd3);

    // Partial mask
    offer(16'hC3A5, 2'b01, 1'b0);
    shiftFrame(16'hC3A5, 2'b01, -1);
    loadPhase(2'b01);

    // Reset mid-shift
    offer(16'hFFFF, 2'b11, 1'b0);
    repeat (18) tick();
    chk("mid_din", 32'(dac_din), 32'(2'b11));
    chk("mid_sclk", 32'(dac_sclk), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_outs", {26'd0, busy, dac_sclk, dac_din, dac_load}, 32'd0);
    chk("mid_rst_acks", {30'd0, ack_data, ack_set}, 32'd0);
    chk("mid_rst_ready", 32'(din_ready), 32'd1);
    for (int i = 0; i < 50; i++) begin
      chk("post_rst_load", 32'(dac_load), 32'd0);
      chk("post_rst_ack", 32'(ack_set), 32'd0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
